// File: rtl/clic_gateway_if.sv
// Gateway <-> arbiter/register-file signal bundle for clic_gateway.
// The slave modport is the gateway's view; the master modport is its environment.
interface clic_gateway_if #(
  parameter int unsigned N_SOURCE = 256,
  parameter int unsigned SrcWidth = $clog2(N_SOURCE)
);
  logic [N_SOURCE-1:0] intr_src_i;
  logic [N_SOURCE-1:0] pol_i;
  logic [N_SOURCE-1:0] trig_i;
  logic [N_SOURCE-1:0] claim_i;
  logic                sw_we_i;
  logic [SrcWidth-1:0] sw_idx_i;
  logic                sw_wdata_i;
  logic [N_SOURCE-1:0] ovf_clr_i;
  logic [N_SOURCE-1:0] ip_o;
  logic [N_SOURCE-1:0] le_o;
  logic [N_SOURCE-1:0] ovf_o;

  modport slave (
    input  intr_src_i, pol_i, trig_i, claim_i,
    input  sw_we_i, sw_idx_i, sw_wdata_i, ovf_clr_i,
    output ip_o, le_o, ovf_o
  );

  modport master (
    output intr_src_i, pol_i, trig_i, claim_i,
    output sw_we_i, sw_idx_i, sw_wdata_i, ovf_clr_i,
    input  ip_o, le_o, ovf_o
  );
endinterface

// File: rtl/clic_gateway.sv
// Per-source CLIC interrupt gateway: polarity, level/edge trigger, pending and lost-edge flags.
// Define CLIC_GATEWAY_SYNC_EN to insert a 2-flop synchronizer per source (asynchronous sources).
module clic_gateway #(
  parameter int unsigned N_SOURCE = 256,
  parameter int unsigned SrcWidth = $clog2(N_SOURCE)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  clic_gateway_if.slave   gw
);

  logic [N_SOURCE-1:0] act;
  logic [N_SOURCE-1:0] src_d;
  logic [N_SOURCE-1:0] src_q;
  logic [N_SOURCE-1:0] prev_q;
  logic [N_SOURCE-1:0] edge_w;
  logic [N_SOURCE-1:0] sw_hit;
  logic [N_SOURCE-1:0] ip_d;
  logic [N_SOURCE-1:0] ip_q;
  logic [N_SOURCE-1:0] ovf_d;
  logic [N_SOURCE-1:0] ovf_q;

  assign act = gw.intr_src_i ^ gw.pol_i;

`ifdef CLIC_GATEWAY_SYNC_EN
  logic [N_SOURCE-1:0] sync1_q;
  logic [N_SOURCE-1:0] sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= act;
      sync2_q <= sync1_q;
    end
  end

  assign src_d = sync2_q;
`else
  assign src_d = act;
`endif

  assign edge_w = src_q & ~prev_q;

  // Edge-mode priority: software write, then new edge, then claim, else hold.
  always_comb begin
    ip_d   = ip_q;
    ovf_d  = ovf_q;
    sw_hit = '0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      sw_hit[i] = gw.sw_we_i && (gw.sw_idx_i == SrcWidth'(i));
      if (!gw.trig_i[i]) begin
        ip_d[i] = src_q[i];
      end else begin
        if (sw_hit[i])          ip_d[i] = gw.sw_wdata_i;
        else if (edge_w[i])     ip_d[i] = 1'b1;
        else if (gw.claim_i[i]) ip_d[i] = 1'b0;

        if (edge_w[i] && ip_q[i] && !gw.claim_i[i] && !sw_hit[i]) ovf_d[i] = 1'b1;
        else if (gw.ovf_clr_i[i])                                  ovf_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q  <= '0;
      prev_q <= '0;
      ip_q   <= '0;
      ovf_q  <= '0;
    end else begin
      src_q  <= src_d;
      prev_q <= src_q;
      ip_q   <= ip_d;
      ovf_q  <= ovf_d;
    end
  end

  assign gw.ip_o  = ip_q;
  assign gw.ovf_o = ovf_q;
  assign gw.le_o  = gw.trig_i;

endmodule

// File: tb/tb_clic_gateway.sv
// Self-checking bench for clic_gateway: directed test-plan steps followed by a random phase,
// all compared against a behavioural pending/overflow model.
module tb_clic_gateway;
  localparam int unsigned N = 12;
  localparam int unsigned W = $clog2(N);
`ifdef CLIC_GATEWAY_SYNC_EN
  localparam int unsigned D = 3;
`else
  localparam int unsigned D = 1;
`endif
  localparam int unsigned L = D + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  clic_gateway_if #(.N_SOURCE(N)) bus ();

  clic_gateway #(.N_SOURCE(N)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .gw     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: delay line of the active value, pending bits and overflow flags.
  logic [N-1:0] m_pipe [0:3];
  logic [N-1:0] m_ip;
  logic [N-1:0] m_ovf;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_pipe[k] = '0;
    m_ip  = '0;
    m_ovf = '0;
  endtask

  task automatic model_clock();
    logic [N-1:0] src, prv, edg, act;
    logic sw;
    src = m_pipe[D-1];
    prv = m_pipe[D];
    edg = src & ~prv;
    act = bus.intr_src_i ^ bus.pol_i;
    for (int i = 0; i < N; i++) begin
      sw = bus.sw_we_i && (int'(bus.sw_idx_i) == i);
      if (!bus.trig_i[i]) begin
        m_ip[i] = src[i];
      end else begin
        if (edg[i] && m_ip[i] && !bus.claim_i[i] && !sw) m_ovf[i] = 1'b1;
        else if (bus.ovf_clr_i[i])                       m_ovf[i] = 1'b0;
        if (sw)                  m_ip[i] = bus.sw_wdata_i;
        else if (edg[i])         m_ip[i] = 1'b1;
        else if (bus.claim_i[i]) m_ip[i] = 1'b0;
      end
    end
    for (int k = 3; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = act;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
    check("ip_model", bus.ip_o, m_ip);
    check("ovf_model", bus.ovf_o, m_ovf);
    check("le", bus.le_o, bus.trig_i);
  endtask

  task automatic bit_chk(input string tag, input logic got, input logic exp);
    check(tag, {{(N-1){1'b0}}, got}, {{(N-1){1'b0}}, exp});
  endtask

  initial begin
    bus.intr_src_i = '0;
    bus.pol_i      = '0;
    bus.trig_i     = '0;
    bus.claim_i    = '0;
    bus.sw_we_i    = 1'b0;
    bus.sw_idx_i   = '0;
    bus.sw_wdata_i = 1'b0;
    bus.ovf_clr_i  = '0;
    model_reset();

    // Reset state; le_o follows trig_i even while in reset.
    repeat (3) @(posedge clk);
    #1;
    bus.trig_i = 12'h2A4;  // sources 2,5,7,9 edge
    bus.trig_i[9] = 1'b0;
    #1;
    check("rst_ip", bus.ip_o, '0);
    check("rst_ovf", bus.ovf_o, '0);
    check("rst_le", bus.le_o, 12'h0A4);
    bus.pol_i[5]      = 1'b1;
    bus.intr_src_i[5] = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) tick();

    // Level source 3.
    bus.intr_src_i[3] = 1'b1;
    repeat (L - 1) tick();
    bit_chk("lvl_lat_lo", bus.ip_o[3], 1'b0);
    tick();
    bit_chk("lvl_hi", bus.ip_o[3], 1'b1);
    repeat (8) tick();
    bus.intr_src_i[3] = 1'b0;
    repeat (L) tick();
    bit_chk("lvl_lo", bus.ip_o[3], 1'b0);
    bit_chk("lvl_ovf", bus.ovf_o[3], 1'b0);

    // Edge, falling polarity, source 5: 1-cycle low pulse then claim.
    bus.intr_src_i[5] = 1'b0;
    tick();
    bus.intr_src_i[5] = 1'b1;
    repeat (L - 1) tick();
    bit_chk("e5_set", bus.ip_o[5], 1'b1);
    repeat (6) tick();
    bit_chk("e5_hold", bus.ip_o[5], 1'b1);
    bus.claim_i[5] = 1'b1;
    tick();
    bus.claim_i[5] = 1'b0;
    bit_chk("e5_claim", bus.ip_o[5], 1'b0);

    // Two edges on source 7 without claim -> overflow; then clear.
    bus.intr_src_i[7] = 1'b1; tick();
    bus.intr_src_i[7] = 1'b0; repeat (2) tick();
    bus.intr_src_i[7] = 1'b1; tick();
    bus.intr_src_i[7] = 1'b0;
    repeat (L) tick();
    bit_chk("e7_ip", bus.ip_o[7], 1'b1);
    bit_chk("e7_ovf", bus.ovf_o[7], 1'b1);
    bus.ovf_clr_i[7] = 1'b1;
    tick();
    bus.ovf_clr_i[7] = 1'b0;
    bit_chk("e7_clr_ovf", bus.ovf_o[7], 1'b0);
    bit_chk("e7_clr_ip", bus.ip_o[7], 1'b1);

    // Source 2: edge coinciding with claim, then with a software clear.
    bus.intr_src_i[2] = 1'b1; tick();
    bus.intr_src_i[2] = 1'b0; repeat (L + 1) tick();
    bit_chk("e2_pend", bus.ip_o[2], 1'b1);
    bus.intr_src_i[2] = 1'b1; tick();
    bus.intr_src_i[2] = 1'b0;
    repeat (L - 2) tick();
    bus.claim_i[2] = 1'b1;
    tick();
    bus.claim_i[2] = 1'b0;
    bit_chk("e2_claim_ip", bus.ip_o[2], 1'b1);
    bit_chk("e2_claim_ovf", bus.ovf_o[2], 1'b0);
    repeat (2) tick();
    bus.intr_src_i[2] = 1'b1; tick();
    bus.intr_src_i[2] = 1'b0;
    repeat (L - 2) tick();
    bus.sw_we_i = 1'b1; bus.sw_idx_i = W'(2); bus.sw_wdata_i = 1'b0;
    tick();
    bus.sw_we_i = 1'b0;
    bit_chk("e2_sw_ip", bus.ip_o[2], 1'b0);
    bit_chk("e2_sw_ovf", bus.ovf_o[2], 1'b0);

    // Software write to level source 9 is ignored; in edge mode it sets pending.
    bus.sw_we_i = 1'b1; bus.sw_idx_i = W'(9); bus.sw_wdata_i = 1'b1;
    tick();
    bit_chk("sw9_lvl", bus.ip_o[9], 1'b0);
    bus.trig_i[9] = 1'b1;
    tick();
    bus.sw_we_i = 1'b0;
    bit_chk("sw9_edge", bus.ip_o[9], 1'b1);

    // Out-of-range index is ignored.
    bus.sw_we_i = 1'b1; bus.sw_idx_i = W'(13); bus.sw_wdata_i = 1'b1;
    tick();
    bus.sw_we_i = 1'b0;

    // Random phase.
    for (int c = 0; c < 400; c++) begin
      bus.intr_src_i = N'($urandom);
      if ($urandom_range(0, 15) == 0) bus.pol_i  = N'($urandom);
      if ($urandom_range(0, 15) == 0) bus.trig_i = N'($urandom);
      bus.claim_i    = ($urandom_range(0, 2) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
      bus.sw_we_i    = ($urandom_range(0, 4) == 0);
      bus.sw_idx_i   = W'($urandom_range(0, 15));
      bus.sw_wdata_i = 1'($urandom);
      bus.ovf_clr_i  = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      tick();
    end

    // Asynchronous reset while pending.
    bus.claim_i = '0; bus.sw_we_i = 1'b0; bus.ovf_clr_i = '0;
    bus.trig_i = '1;
    bus.sw_we_i = 1'b1; bus.sw_idx_i = W'(4); bus.sw_wdata_i = 1'b1;
    tick();
    bus.sw_we_i = 1'b0;
    bit_chk("pre_rst_ip4", bus.ip_o[4], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ip", bus.ip_o, '0);
    check("async_rst_ovf", bus.ovf_o, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus.intr_src_i = N'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
